// File: rtl/mips_alu_exec_unit.sv
// Registered execute stage: ALU-control decode, 32-bit ALU, PC adders.
// Define ALU_OVERFLOW_EN to build signed-overflow detection on ovf.
module mips_alu_exec_unit #(
  parameter int PC_INC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        alu_op1,
  input  logic        alu_op0,
  input  logic [5:0]  funct,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] pc,
  input  logic [15:0] imm,
  output logic        out_valid,
  output logic [3:0]  alu_ctl,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] pc_plus_4,
  output logic [31:0] branch_target,
  output logic        ovf
);

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_NOR = 4'b1100;
  localparam logic [3:0] C_INV = 4'b1111;

  logic [3:0]  ctl_c;
  logic [31:0] res_c;
  logic [31:0] seq_c;
  logic [31:0] off_c;

  logic        valid_d, valid_q;
  logic [3:0]  ctl_d, ctl_q;
  logic [31:0] res_d, res_q;
  logic        zero_d, zero_q;
  logic [31:0] pc4_d, pc4_q;
  logic [31:0] bt_d, bt_q;

  always_comb begin
    ctl_c = C_INV;
    case ({alu_op1, alu_op0})
      2'b00: ctl_c = C_ADD;
      2'b01: ctl_c = C_SUB;
      2'b11: ctl_c = C_AND;
      default: begin
        case (funct)
          6'b100000: ctl_c = C_ADD;
          6'b100010: ctl_c = C_SUB;
          6'b100100: ctl_c = C_AND;
          6'b100101: ctl_c = C_OR;
          6'b101010: ctl_c = C_SLT;
          6'b100111: ctl_c = C_NOR;
          default:   ctl_c = C_INV;
        endcase
      end
    endcase
  end

  always_comb begin
    res_c = 32'd0;
    case (ctl_c)
      C_AND: res_c = op_a & op_b;
      C_OR:  res_c = op_a | op_b;
      C_NOR: res_c = ~(op_a | op_b);
      C_ADD: res_c = op_a + op_b;
      C_SUB: res_c = op_a - op_b;
      C_SLT: res_c = {31'd0, $signed(op_a) < $signed(op_b)};
      default: res_c = 32'd0;
    endcase
  end

  // Branch offset is a word offset relative to the next sequential pc.
  assign seq_c = pc + 32'(PC_INC);
  assign off_c = {{14{imm[15]}}, imm, 2'b00};

  always_comb begin
    valid_d = in_valid;
    ctl_d   = ctl_q;
    res_d   = res_q;
    zero_d  = zero_q;
    pc4_d   = pc4_q;
    bt_d    = bt_q;
    if (in_valid) begin
      ctl_d  = ctl_c;
      res_d  = res_c;
      zero_d = (res_c == 32'd0);
      pc4_d  = seq_c;
      bt_d   = seq_c + off_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctl_q   <= 4'd0;
      res_q   <= 32'd0;
      zero_q  <= 1'b0;
      pc4_q   <= 32'd0;
      bt_q    <= 32'd0;
    end else begin
      valid_q <= valid_d;
      ctl_q   <= ctl_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      pc4_q   <= pc4_d;
      bt_q    <= bt_d;
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic ovf_c;
  logic ovf_d, ovf_q;

  always_comb begin
    ovf_c = 1'b0;
    case (ctl_c)
      C_ADD: ovf_c = (op_a[31] == op_b[31]) && (res_c[31] != op_a[31]);
      C_SUB: ovf_c = (op_a[31] != op_b[31]) && (res_c[31] != op_a[31]);
      default: ovf_c = 1'b0;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) ovf_d = ovf_c;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign out_valid     = valid_q;
  assign alu_ctl       = ctl_q;
  assign alu_result    = res_q;
  assign zero          = zero_q;
  assign pc_plus_4     = pc4_q;
  assign branch_target = bt_q;

endmodule

// File: tb/tb_mips_alu_exec_unit.sv
// Directed table-driven bench for mips_alu_exec_unit.
// Honours ALU_OVERFLOW_EN for the expected ovf value.
module tb_mips_alu_exec_unit;

`ifdef ALU_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        alu_op1, alu_op0;
  logic [5:0]  funct;
  logic [31:0] op_a, op_b, pc;
  logic [15:0] imm;
  logic        out_valid;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] pc_plus_4, branch_target;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_alu_exec_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .alu_op1(alu_op1), .alu_op0(alu_op0), .funct(funct),
    .op_a(op_a), .op_b(op_b), .pc(pc), .imm(imm),
    .out_valid(out_valid), .alu_ctl(alu_ctl),
    .alu_result(alu_result), .zero(zero),
    .pc_plus_4(pc_plus_4), .branch_target(branch_target),
    .ovf(ovf)
  );

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [15:0] imm;
    logic [3:0]  ctl;
    logic [31:0] res;
    logic        z;
    logic [31:0] pc4;
    logic [31:0] bt;
    logic        ov;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".alu_ctl"}, {28'd0, alu_ctl}, 32'd0);
    chk({tag, ".alu_result"}, alu_result, 32'd0);
    chk({tag, ".zero"}, {31'd0, zero}, 32'd0);
    chk({tag, ".pc_plus_4"}, pc_plus_4, 32'd0);
    chk({tag, ".branch_target"}, branch_target, 32'd0);
    chk({tag, ".ovf"}, {31'd0, ovf}, 32'd0);
  endtask

  task automatic drive_rand;
    {alu_op1, alu_op0} = 2'($urandom);
    funct = 6'($urandom);
    op_a  = $urandom;
    op_b  = $urandom;
    pc    = $urandom;
    imm   = 16'($urandom);
  endtask

  initial begin
    //         op     fn        a             b             pc            imm      ctl   res           z     pc4           bt            ov
    vecs[0]  = '{2'b10, 6'h20, 32'd5,        32'd7,        32'h40,       16'hFFFE, 4'h2, 32'd12,       1'b0, 32'h44,       32'h3C,       1'b0};
    vecs[1]  = '{2'b10, 6'h22, 32'd9,        32'd9,        32'hFFFFFFFC, 16'h0000, 4'h6, 32'd0,        1'b1, 32'h0,        32'h0,        1'b0};
    vecs[2]  = '{2'b10, 6'h2A, 32'hFFFFFFFF, 32'd1,        32'h100,      16'h0001, 4'h7, 32'd1,        1'b0, 32'h104,      32'h108,      1'b0};
    vecs[3]  = '{2'b10, 6'h2A, 32'd1,        32'hFFFFFFFF, 32'h0,        16'h7FFF, 4'h7, 32'd0,        1'b1, 32'h4,        32'h20000,    1'b0};
    vecs[4]  = '{2'b10, 6'h27, 32'd0,        32'd0,        32'h1000,     16'h0000, 4'hC, 32'hFFFFFFFF, 1'b0, 32'h1004,     32'h1004,     1'b0};
    vecs[5]  = '{2'b10, 6'h00, 32'd123,      32'd456,      32'h1000,     16'h8000, 4'hF, 32'd0,        1'b1, 32'h1004,     32'hFFFE1004, 1'b0};
    vecs[6]  = '{2'b11, 6'h20, 32'hF0,       32'h3C,       32'h2000,     16'h0010, 4'h0, 32'h30,       1'b0, 32'h2004,     32'h2044,     1'b0};
    vecs[7]  = '{2'b00, 6'h15, 32'h7FFFFFFF, 32'd1,        32'h3000,     16'h0000, 4'h2, 32'h80000000, 1'b0, 32'h3004,     32'h3004,     1'b1};
    vecs[8]  = '{2'b01, 6'h3F, 32'h80000000, 32'd1,        32'h3000,     16'h0000, 4'h6, 32'h7FFFFFFF, 1'b0, 32'h3004,     32'h3004,     1'b1};
    vecs[9]  = '{2'b10, 6'h25, 32'hF0,       32'h0F,       32'h3000,     16'h0000, 4'h1, 32'hFF,       1'b0, 32'h3004,     32'h3004,     1'b0};
    vecs[10] = '{2'b10, 6'h24, 32'hFF00,     32'h0FF0,     32'h3000,     16'h0000, 4'h0, 32'h0F00,     1'b0, 32'h3004,     32'h3004,     1'b0};
    vecs[11] = '{2'b01, 6'h00, 32'd3,        32'd5,        32'h3000,     16'h0000, 4'h6, 32'hFFFFFFFE, 1'b0, 32'h3004,     32'h3004,     1'b0};

    rst = 1'b1;
    in_valid = 1'b1;
    drive_rand();
    repeat (2) begin
      @(posedge clk);
      #1 drive_rand();
    end
    chk_all_zero("reset");

    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk_all_zero("idle");

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      {alu_op1, alu_op0} = vecs[i].op;
      funct = vecs[i].fn;
      op_a  = vecs[i].a;
      op_b  = vecs[i].b;
      pc    = vecs[i].pc;
      imm   = vecs[i].imm;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d.alu_ctl", i), {28'd0, alu_ctl}, {28'd0, vecs[i].ctl});
      chk($sformatf("v%0d.alu_result", i), alu_result, vecs[i].res);
      chk($sformatf("v%0d.zero", i), {31'd0, zero}, {31'd0, vecs[i].z});
      chk($sformatf("v%0d.pc_plus_4", i), pc_plus_4, vecs[i].pc4);
      chk($sformatf("v%0d.branch_target", i), branch_target, vecs[i].bt);
      chk($sformatf("v%0d.ovf", i), {31'd0, ovf},
          {31'd0, vecs[i].ov & OVF_EN});
    end

    // Hold: new inputs without in_valid must not disturb vector 7 results.
    @(negedge clk);
    in_valid = 1'b1;
    {alu_op1, alu_op0} = vecs[7].op;
    funct = vecs[7].fn;
    op_a  = vecs[7].a;
    op_b  = vecs[7].b;
    pc    = vecs[7].pc;
    imm   = vecs[7].imm;
    @(negedge clk);
    in_valid = 1'b0;
    {alu_op1, alu_op0} = 2'b10;
    funct = 6'h20;
    op_a  = 32'd1;
    op_b  = 32'd2;
    pc    = 32'h500;
    imm   = 16'h0004;
    repeat (2) @(posedge clk);
    #1;
    chk("hold.out_valid", {31'd0, out_valid}, 32'd0);
    chk("hold.alu_ctl", {28'd0, alu_ctl}, 32'h2);
    chk("hold.alu_result", alu_result, 32'h80000000);
    chk("hold.pc_plus_4", pc_plus_4, 32'h3004);
    chk("hold.ovf", {31'd0, ovf}, {31'd0, OVF_EN});

    // Reset wins over a simultaneous valid input.
    @(negedge clk);
    in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1 chk_all_zero("rst_prio");

    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
